piso_serializer: RTL

//  Parallel-in/serial-out transmitter: the sending end for our serial shift-register chains.

---
 rtl/piso_serializer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// Takes a WIDTH-bit word on a valid/ready handshake and shifts it out one bit
// per clock. Frame bits are flagged with sout_valid, the final bit with
// sout_last, and a registered done pulse follows every completed frame. An
// optional idle gap of GAP cycles can be forced between frames so that
// downstream receivers can realign.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy,
  output logic             done
);

  // Elaboration-time guard on the legal parameter ranges.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("piso_serializer: WIDTH must be in 2..32");
  end
  if (GAP < 0 || GAP > 15) begin : g_bad_gap
    $error("piso_serializer: GAP must be in 0..15");
  end

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0]      GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
  localparam logic            HAS_GAP  = (GAP > 0);
  localparam logic            MSB_SEL  = (MSB_FIRST != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shreg_nx;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_nx;
  logic [3:0]         gap_cnt;
  logic [3:0]         gap_cnt_nx;
  logic               done_nx;
  logic               at_last;
  logic               accept;

  // One shift step toward the transmit end, zero-filling the vacated bit so
  // the register is empty once the whole frame has left.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_SEL) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  assign at_last    = (bit_cnt == BIT_LAST);
  // Ready depends on state only; a reload on the last bit is only possible
  // when no idle gap has to be inserted.
  assign din_ready  = (state == S_IDLE) | ((state == S_SHIFT) & at_last & ~HAS_GAP);
  assign accept     = din_valid & din_ready;
  assign sout       = MSB_SEL ? shreg[WIDTH-1] : shreg[0];
  assign sout_valid = (state == S_SHIFT);
  assign sout_last  = sout_valid & at_last;
  assign busy       = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, shifter, counter and done-pulse decode.
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    done_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx   = S_SHIFT;
          shreg_nx   = din;
          bit_cnt_nx = '0;
        end
      end
      S_SHIFT: begin
        if (!at_last) begin
          shreg_nx   = shift_once(shreg);
          bit_cnt_nx = bit_cnt + 1'b1;
        end else begin
          done_nx = 1'b1;
          if (accept) begin
            shreg_nx   = din;
            bit_cnt_nx = '0;
          end else begin
            shreg_nx   = shift_once(shreg);
            bit_cnt_nx = '0;
            if (HAS_GAP) begin
              state_nx   = S_GAP;
              gap_cnt_nx = '0;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx   = S_IDLE;
          gap_cnt_nx = '0;
        end else begin
          gap_cnt_nx = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Datapath and done register; reset clears everything so an aborted frame
  // leaves no residue on sout and the next word starts at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      done    <= 1'b0;
    end else begin
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      done    <= done_nx;
    end
  end

endmodule
